// File: rtl/fd_pkg.sv
// fd_pkg
// Shared definitions for the programmable clock divider (fd_prog).
//   fd_state_t  : divider FSM states
//   FD_MIN_DIV  : smallest divide ratio that can be loaded
package fd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fd_state_t;

  localparam int unsigned FD_MIN_DIV = 2;

endpackage

// File: rtl/fd_prog.sv
// fd_prog
// Runtime-programmable integer clock divider with a glitch-free ratio change.
// The divided clock is high for ceil(N/2) cycles and low for the remainder.
// A new ratio is only applied at a period boundary or when the divider starts.
//
// Parameters
//   CNT_W        : width of the ratio and the internal counter
//   DEF_DIV      : ratio in force after reset (2 .. 2^CNT_W-1)
// Ports
//   clk          : clock, all logic on the rising edge
//   rst_n        : asynchronous active-low reset
//   en           : run request
//   ratio_i      : requested divide ratio
//   ratio_load   : one-cycle strobe capturing ratio_i
//   div_o        : divided clock (registered)
//   rise_tick    : pulse on the edge where div_o goes 0->1
//   fall_tick    : pulse on the edge where div_o goes 1->0
//   pending_o    : a loaded ratio is waiting for the next period boundary
//   ratio_err    : pulse when a ratio below the minimum was loaded
//   active_ratio : ratio governing the current period
module fd_prog
  import fd_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] ratio_i,
  input  logic             ratio_load,
  output logic             div_o,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             pending_o,
  output logic             ratio_err,
  output logic [CNT_W-1:0] active_ratio
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(FD_MIN_DIV);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

  fd_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] pend_ratio;
  logic             div_nx;
  logic             wrap;
  logic             apply;
  logic             load_ok;

  // ceil(N/2) written without an N+1 term so it cannot overflow at N = 2^CNT_W-1.
  assign high_len = (active_ratio >> 1) + {{(CNT_W-1){1'b0}}, active_ratio[0]};
  assign wrap     = (cnt == active_ratio - ONE);
  assign cnt_inc  = wrap ? '0 : cnt + ONE;
  assign load_ok  = (ratio_i >= MIN_DIV);

  // Next-state logic. Stopping is only allowed on a wrap, so the last period
  // is always completed; DRAIN keeps counting so a re-enable causes no slip.
  // At a wrap the counter restarts at 0, which is high for any ratio, so the
  // old high_len is still correct on the edge where a new ratio is applied.
  always_comb begin
    state_next = state;
    cnt_nx     = cnt;
    div_nx     = div_o;
    apply      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        div_nx = 1'b0;
        if (en) begin
          state_next = RUN;
          div_nx     = 1'b1;
          apply      = 1'b1;
        end
      end
      RUN, DRAIN: begin
        apply  = wrap;
        cnt_nx = cnt_inc;
        div_nx = (cnt_inc < high_len);
        if (en) begin
          state_next = RUN;
        end else if (wrap) begin
          state_next = IDLE;
          cnt_nx     = '0;
          div_nx     = 1'b0;
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_nx     = '0;
        div_nx     = 1'b0;
      end
    endcase
  end

  // Counter, FSM and output register; ticks are derived from the same
  // transition so they line up with the div_o edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      div_o     <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_nx;
      div_o     <= div_nx;
      rise_tick <= !div_o && div_nx;
      fall_tick <= div_o && !div_nx;
    end
  end

  // Ratio shadow. The apply path uses the pre-edge pend_ratio, so a load on
  // the same edge as an apply stays pending until the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_ratio <= RST_DIV;
      pend_ratio   <= RST_DIV;
      pending_o    <= 1'b0;
      ratio_err    <= 1'b0;
    end else begin
      ratio_err <= ratio_load && !load_ok;
      if (apply && pending_o) begin
        active_ratio <= pend_ratio;
        pending_o    <= 1'b0;
      end
      if (ratio_load && load_ok) begin
        pend_ratio <= ratio_i;
        pending_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fd_prog.sv
// tb_fd_prog
// Directed self-checking bench for fd_prog (CNT_W=8, DEF_DIV=4).
// Inputs change 1 ns after a rising edge; outputs are checked at that time.
module tb_fd_prog;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] ratio_i;
  logic       ratio_load;
  logic       div_o;
  logic       rise_tick;
  logic       fall_tick;
  logic       pending_o;
  logic       ratio_err;
  logic [7:0] active_ratio;

  int n_cmp;
  int n_bad;

  fd_prog #(.CNT_W(8), .DEF_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .ratio_i      (ratio_i),
    .ratio_load   (ratio_load),
    .div_o        (div_o),
    .rise_tick    (rise_tick),
    .fall_tick    (fall_tick),
    .pending_o    (pending_o),
    .ratio_err    (ratio_err),
    .active_ratio (active_ratio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    en         = 1'b0;
    ratio_i    = 8'd0;
    ratio_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({div_o, rise_tick, fall_tick} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got %b want 000", {div_o, rise_tick, fall_tick});
    end
    n_cmp++;
    if ({pending_o, ratio_err} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL reset_flags: got %b want 00", {pending_o, ratio_err});
    end
    n_cmp++;
    if (active_ratio !== 8'd4) begin
      n_bad++;
      $display("[TB] FAIL reset_ratio: got %0d want 4", active_ratio);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (div_o !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL idle_no_en: got %b want 0", div_o);
    end
  endtask

  task automatic test_basic_div4();
    logic [2:0] exp;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp = {((i % 4) < 2), ((i % 4) == 0), ((i % 4) == 2)};
      n_cmp++;
      if ({div_o, rise_tick, fall_tick} !== exp) begin
        n_bad++;
        $display("[TB] FAIL div4_cycle%0d: got %b want %b", i, {div_o, rise_tick, fall_tick}, exp);
      end
    end
    n_cmp++;
    if (active_ratio !== 8'd4) begin
      n_bad++;
      $display("[TB] FAIL div4_ratio: got %0d want 4", active_ratio);
    end
  endtask

  task automatic test_load_mid_period();
    logic [2:0] exp;
    step();
    step();
    ratio_i    = 8'd7;
    ratio_load = 1'b1;
    step();
    ratio_load = 1'b0;
    n_cmp++;
    if ({pending_o, active_ratio} !== {1'b1, 8'd4}) begin
      n_bad++;
      $display("[TB] FAIL load7_pending: got p=%b r=%0d want p=1 r=4", pending_o, active_ratio);
    end
    n_cmp++;
    if ({div_o, rise_tick, fall_tick} !== 3'b001) begin
      n_bad++;
      $display("[TB] FAIL load7_fall: got %b want 001", {div_o, rise_tick, fall_tick});
    end
    step();
    n_cmp++;
    if ({pending_o, div_o} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL load7_wait: got %b want 10", {pending_o, div_o});
    end
    step();
    n_cmp++;
    if ({pending_o, active_ratio, div_o, rise_tick, fall_tick} !== {1'b0, 8'd7, 3'b110}) begin
      n_bad++;
      $display("[TB] FAIL load7_apply: got p=%b r=%0d dvr=%b want p=0 r=7 dvr=110",
               pending_o, active_ratio, {div_o, rise_tick, fall_tick});
    end
    for (int j = 1; j < 14; j++) begin
      step();
      exp = {((j % 7) < 4), ((j % 7) == 0), ((j % 7) == 4)};
      n_cmp++;
      if ({div_o, rise_tick, fall_tick} !== exp) begin
        n_bad++;
        $display("[TB] FAIL div7_cycle%0d: got %b want %b", j, {div_o, rise_tick, fall_tick}, exp);
      end
    end
  endtask

  task automatic test_bad_ratio();
    for (int k = 0; k < 2; k++) begin
      ratio_i    = (k == 0) ? 8'd1 : 8'd0;
      ratio_load = 1'b1;
      step();
      ratio_load = 1'b0;
      n_cmp++;
      if ({ratio_err, pending_o, active_ratio} !== {2'b10, 8'd7}) begin
        n_bad++;
        $display("[TB] FAIL bad_ratio%0d: got e=%b p=%b r=%0d want e=1 p=0 r=7",
                 ratio_i, ratio_err, pending_o, active_ratio);
      end
      step();
      n_cmp++;
      if (ratio_err !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL bad_ratio_pulse%0d: got %b want 0", ratio_i, ratio_err);
      end
    end
  endtask

  task automatic test_load_on_wrap();
    logic [2:0] exp;
    repeat (3) step();
    ratio_i    = 8'd5;
    ratio_load = 1'b1;
    step();
    ratio_load = 1'b0;
    n_cmp++;
    if ({pending_o, active_ratio, div_o, rise_tick} !== {1'b1, 8'd7, 2'b11}) begin
      n_bad++;
      $display("[TB] FAIL wrap_load: got p=%b r=%0d dr=%b want p=1 r=7 dr=11",
               pending_o, active_ratio, {div_o, rise_tick});
    end
    ratio_i    = 8'd3;
    ratio_load = 1'b1;
    step();
    ratio_load = 1'b0;
    repeat (5) step();
    n_cmp++;
    if ({pending_o, active_ratio} !== {1'b1, 8'd7}) begin
      n_bad++;
      $display("[TB] FAIL wrap_hold: got p=%b r=%0d want p=1 r=7", pending_o, active_ratio);
    end
    step();
    n_cmp++;
    if ({pending_o, active_ratio, div_o, rise_tick} !== {1'b0, 8'd3, 2'b11}) begin
      n_bad++;
      $display("[TB] FAIL wrap_apply: got p=%b r=%0d dr=%b want p=0 r=3 dr=11",
               pending_o, active_ratio, {div_o, rise_tick});
    end
    for (int j = 1; j < 6; j++) begin
      step();
      exp = {((j % 3) < 2), ((j % 3) == 0), ((j % 3) == 2)};
      n_cmp++;
      if ({div_o, rise_tick, fall_tick} !== exp) begin
        n_bad++;
        $display("[TB] FAIL div3_cycle%0d: got %b want %b", j, {div_o, rise_tick, fall_tick}, exp);
      end
    end
  endtask

  task automatic test_drain();
    logic [2:0] exp;
    step();
    ratio_i    = 8'd6;
    ratio_load = 1'b1;
    step();
    ratio_load = 1'b0;
    step();
    step();
    n_cmp++;
    if (active_ratio !== 8'd6) begin
      n_bad++;
      $display("[TB] FAIL drain_ratio: got %0d want 6", active_ratio);
    end
    step();
    en = 1'b0;
    for (int e = 1; e < 7; e++) begin
      step();
      exp = {(e == 1), 1'b0, (e == 2)};
      n_cmp++;
      if ({div_o, rise_tick, fall_tick} !== exp) begin
        n_bad++;
        $display("[TB] FAIL drain_cycle%0d: got %b want %b", e, {div_o, rise_tick, fall_tick}, exp);
      end
    end
    en = 1'b1;
    step();
    n_cmp++;
    if ({div_o, rise_tick, fall_tick} !== 3'b110) begin
      n_bad++;
      $display("[TB] FAIL restart: got %b want 110", {div_o, rise_tick, fall_tick});
    end
    step();
    step();
    en = 1'b0;
    step();
    en = 1'b1;
    n_cmp++;
    if ({div_o, rise_tick, fall_tick} !== 3'b001) begin
      n_bad++;
      $display("[TB] FAIL reenable_fall: got %b want 001", {div_o, rise_tick, fall_tick});
    end
    step();
    step();
    n_cmp++;
    if ({div_o, rise_tick, fall_tick} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL reenable_low: got %b want 000", {div_o, rise_tick, fall_tick});
    end
    step();
    n_cmp++;
    if ({div_o, rise_tick, fall_tick} !== 3'b110) begin
      n_bad++;
      $display("[TB] FAIL reenable_wrap: got %b want 110", {div_o, rise_tick, fall_tick});
    end
    for (int j = 1; j < 6; j++) begin
      step();
      exp = {(j < 3), 1'b0, (j == 3)};
      n_cmp++;
      if ({div_o, rise_tick, fall_tick} !== exp) begin
        n_bad++;
        $display("[TB] FAIL div6_cycle%0d: got %b want %b", j, {div_o, rise_tick, fall_tick}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    step();
    n_cmp++;
    if ({div_o, rise_tick, active_ratio} !== {2'b11, 8'd6}) begin
      n_bad++;
      $display("[TB] FAIL pre_reset: got dr=%b r=%0d want dr=11 r=6", {div_o, rise_tick}, active_ratio);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({div_o, rise_tick, fall_tick} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL async_reset_out: got %b want 000", {div_o, rise_tick, fall_tick});
    end
    n_cmp++;
    if ({pending_o, active_ratio} !== {1'b0, 8'd4}) begin
      n_bad++;
      $display("[TB] FAIL async_reset_ratio: got p=%b r=%0d want p=0 r=4", pending_o, active_ratio);
    end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({div_o, rise_tick, active_ratio} !== {2'b11, 8'd4}) begin
      n_bad++;
      $display("[TB] FAIL post_reset_start: got dr=%b r=%0d want dr=11 r=4", {div_o, rise_tick}, active_ratio);
    end
    step();
    n_cmp++;
    if ({div_o, rise_tick, fall_tick} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL post_reset_run: got %b want 100", {div_o, rise_tick, fall_tick});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic_div4();
    test_load_mid_period();
    test_bad_ratio();
    test_load_on_wrap();
    test_drain();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fd_prog.md
# fd_prog

Parametrised, runtime-programmable integer clock divider that replaces the fixed divide-by-N blocks in the DLL clock path. It produces a registered divided clock `div_o` with near-50 % duty for any ratio from 2 to 2^CNT_W−1. Ratio changes are applied only at period boundaries, so the output never glitches. Start/stop is controlled by an enable, and rise/fall strobes are provided for downstream phase-detector logic.

## Interface
- `CNT_W`, 8, width of the ratio and the internal counter.
- `DEF_DIV`, 4, ratio loaded at reset; must be ≥ 2 and < 2^CNT_W.
- `clk` input 1: single clock; all logic is on the posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: run request.
- `ratio_i` input CNT_W: requested divide ratio N.
- `ratio_load` input 1: one-cycle strobe that captures `ratio_i`.
- `div_o` output 1: divided clock, registered.
- `rise_tick` output 1: one-cycle pulse on the same edge `div_o` goes 0→1.
- `fall_tick` output 1: one-cycle pulse on the same edge `div_o` goes 1→0.
- `pending_o` output 1: a loaded ratio is waiting to be applied.
- `ratio_err` output 1: one-cycle pulse when a rejected ratio is loaded.
- `active_ratio` output CNT_W: ratio governing the current period.

## Operation
- Reset values:
  - `cnt` = 0, `div_o` = 0, both ticks = 0, `ratio_err` = 0.
  - `pending_o` = 0.
  - `active_ratio` = `pend_ratio` = DEF_DIV.
  - State = IDLE.
- The high phase length is H = (N+1)>>1 and the low phase is N−H.
  - Even N: 50 % duty.
  - Odd N: high phase is one cycle longer.
- In RUN, the counter follows `cnt_next = (cnt == N−1) ? 0 : cnt+1`, and `div_o <= (cnt_next < H)`.
- FSM states:
  - IDLE: `div_o` = 0 and `cnt` = 0. When `en`=1: apply pending ratio if any, set `cnt` = 0 and `div_o` = 1, pulse `rise_tick`, go to RUN.
  - RUN: normal counting. When `en`=0, go to DRAIN.
  - DRAIN: keep counting. At `cnt == N−1`, go to IDLE with `div_o` = 0. If `en` returns high before the wrap, go back to RUN with no gap or phase slip.
- Ratio load:
  - On `ratio_load`, if 2 ≤ `ratio_i`: `pend_ratio` ← `ratio_i` and `pending_o` ← 1.
  - Otherwise the value is ignored and `ratio_err` pulses.
  - A new load while `pending_o`=1 overwrites the pending value (last write wins).
- Apply: at the wrap edge (`cnt == N−1` in RUN or DRAIN), or at IDLE→RUN:
  - If `pending_o`: `active_ratio` ← `pend_ratio` and `pending_o` ← 0.
  - The new period uses the new ratio from its first cycle.
- Simultaneous events:
  - A load on the same edge as a wrap is not applied at that wrap. It takes effect at the following wrap, because the apply path uses the pre-edge `pend_ratio`.
  - In IDLE with `en`=0, a load updates the pending value only; it is applied at start.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). `div_o` may truncate a period; this is accepted.

## Timing
- Start latency: `en` sampled high at edge k → `div_o` = 1 after edge k.
- Period: exactly N clk cycles per `div_o` period once running.
- Ticks are registered and coincide with the `div_o` transition edge, not a cycle later.
- Stop latency: at most N−1 cycles after `en` falls. The last period always completes.
- Ratio change latency: takes effect at the first wrap strictly after the load edge.

## Structure
- Shared package `fd_pkg` holds:
  - the FSM state enum `fd_state_t` {IDLE, RUN, DRAIN};
  - the constant `FD_MIN_DIV` = 2.
- No sub-module. One counter/FSM process and one ratio-shadow process.
- Target size: roughly 150–200 lines of RTL.

## Test plan
- Reset release, `en`=1, N=4 → `div_o` pattern 1100 repeating; `rise_tick` every 4 cycles; `active_ratio`=4.
- Load N=7 mid-period → `pending_o`=1 until the next wrap, then high 4 / low 3 from the next period; no glitch at the switch.
- Load N=1, then N=0 → `ratio_err` pulses each time; `active_ratio` and `pending_o` are unchanged.
- Load on the wrap edge, then a second load before the next wrap → only the second value is applied, one wrap later.
- Drop `en` at `cnt`=1 with N=6 → period finishes, IDLE with `div_o`=0; re-raise `en` during DRAIN → continuous output with period 6.
- Assert `rst_n`=0 mid high-phase → `div_o`, ticks and `cnt` go to 0 immediately; `active_ratio` returns to DEF_DIV.
